// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and widths for the game
// time sequencer and its prescaler.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RUN    = 3'd2,
      ST_PAUSED = 3'd3,
      ST_OVER   = 3'd4
   } game_state_t;

   localparam int TIME_W = 8;
   localparam logic [TIME_W-1:0] TIME_MAX = '1;

   localparam int BONUS_MAX_DFLT = 15;

   function automatic int bonus_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   localparam int BONUS_W = bonus_w(BONUS_MAX_DFLT);

endpackage

// File: rtl/game_time_controller_tick_prescaler.sv
// tick_prescaler: divides clk by DIV while enabled; emits a
// one-cycle tick on the cycle the count sits at DIV-1.
module tick_prescaler #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && !clr && (cnt == LAST);

   // count while enabled, hold otherwise, wrap at DIV-1
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/game_time_controller.sv
// game_time_controller: game FSM, 1 Hz countdown pulses and
// hit-bonus increments feeding the 8-bit time counter.
module game_time_controller
   import game_pkg::*;
#(
   parameter int CLK_HZ        = 100_000_000,
   parameter int TICK_HZ       = 1,
   parameter int BONUS_PER_HIT = 2,
   parameter int BONUS_MAX     = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              hit,
   input  logic [TIME_W-1:0] time_count,
   output logic              counter_rst,
   output logic              increment,
   output logic              decrement,
   output logic              running,
   output logic              game_over
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int BW  = bonus_w(BONUS_MAX);
   localparam int SW  = bonus_w(BONUS_MAX + BONUS_PER_HIT) + 1;

   game_state_t   state;
   logic          tick_pend;
   logic [BW-1:0] bonus_pend;
   logic [BW-1:0] bonus_nx;
   logic [SW-1:0] bonus_sum;

   logic in_run;
   logic in_pause;
   logic at_zero;
   logic go_over;
   logic run_stay;
   logic proj_zero;
   logic proj_top;
   logic presc_clr;
   logic tick;
   logic tick_any;
   logic hit_ok;
   logic dec_go;
   logic inc_go;

   assign in_run   = (state == ST_RUN);
   assign in_pause = (state == ST_PAUSED);
   assign at_zero  = (time_count == '0);
   assign go_over  = in_run && at_zero;

   // Staying in RUN this cycle: not leaving for OVER or PAUSED.
   // The prescaler only advances here, so a pause taken at
   // count N resumes from N.
   assign run_stay  = in_run && !at_zero && !pause;
   assign presc_clr = !(in_run || in_pause);

   // The fed-back count lags a pulse already on the wire by one
   // cycle; project it so limits hold across that lag.
   assign proj_zero = at_zero ||
                      (decrement && time_count == TIME_W'(1));
   assign proj_top  = (time_count == TIME_MAX) ||
                      (increment &&
                       time_count == TIME_MAX - TIME_W'(1));

   tick_prescaler #(
      .DIV (DIV)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (run_stay),
      .clr   (presc_clr),
      .tick  (tick)
   );

   // A fresh tick is issued the same cycle; it never waits a
   // cycle behind tick_pend, and a second tick merges into it.
   assign tick_any = tick || tick_pend;
   assign hit_ok   = in_run && hit;

   assign dec_go = run_stay && tick_any && !proj_zero;
   assign inc_go = run_stay && !tick_any &&
                   (bonus_pend != '0) &&
                   !proj_top && !proj_zero;

   // next bonus: add hit credit, take issued increment, saturate
   always_comb begin
      bonus_sum = SW'(bonus_pend);
      if (hit_ok) begin
         bonus_sum = bonus_sum + SW'(BONUS_PER_HIT);
      end
      if (inc_go) begin
         bonus_sum = bonus_sum - SW'(1);
      end
      if (bonus_sum > SW'(BONUS_MAX)) begin
         bonus_nx = BW'(BONUS_MAX);
      end else begin
         bonus_nx = bonus_sum[BW-1:0];
      end
   end

   // game FSM with registered status and pulse outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         counter_rst <= 1'b0;
         increment   <= 1'b0;
         decrement   <= 1'b0;
         running     <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         counter_rst <= 1'b0;
         increment   <= inc_go;
         decrement   <= dec_go;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state       <= ST_LOAD;
                  counter_rst <= 1'b1;
               end
            end
            ST_LOAD: begin
               state   <= ST_RUN;
               running <= 1'b1;
            end
            ST_RUN: begin
               if (at_zero) begin
                  state     <= ST_OVER;
                  running   <= 1'b0;
                  game_over <= 1'b1;
               end else if (pause) begin
                  state   <= ST_PAUSED;
                  running <= 1'b0;
               end
            end
            ST_PAUSED: begin
               if (pause) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_OVER: begin
               if (start) begin
                  state       <= ST_LOAD;
                  game_over   <= 1'b0;
                  counter_rst <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               running   <= 1'b0;
               game_over <= 1'b0;
            end
         endcase
      end
   end

   // pending tick / bonus: update in RUN, hold in PAUSED,
   // clear everywhere else and on entry to OVER
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_pend  <= 1'b0;
         bonus_pend <= '0;
      end else if (presc_clr || go_over) begin
         tick_pend  <= 1'b0;
         bonus_pend <= '0;
      end else if (in_run) begin
         tick_pend  <= tick_any && !dec_go;
         bonus_pend <= bonus_nx;
      end
   end

   a_inc_dec_excl : assert property (
      @(posedge clk) disable iff (!reset)
      !(increment && decrement)
   );

endmodule

// File: tb/tb_game_time_controller.sv
// tb_game_time_controller: directed scenarios against a
// downstream counter model that reloads to 20.
module tb_game_time_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic       hit;
   logic [7:0] time_count;
   logic       counter_rst;
   logic       increment;
   logic       decrement;
   logic       running;
   logic       game_over;

   logic [7:0] model_cnt;
   logic [7:0] force_val;
   logic       force_en;

   int n_cmp     = 0;
   int n_bad     = 0;
   int inc_total = 0;
   int dec_total = 0;
   int both_cnt  = 0;

   game_time_controller #(
      .CLK_HZ        (10),
      .TICK_HZ       (1),
      .BONUS_PER_HIT (2),
      .BONUS_MAX     (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .hit         (hit),
      .time_count  (time_count),
      .counter_rst (counter_rst),
      .increment   (increment),
      .decrement   (decrement),
      .running     (running),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   assign time_count = force_en ? force_val : model_cnt;

   // downstream 8-bit time counter
   always @(posedge clk) begin
      if (!reset) begin
         model_cnt <= 8'd0;
      end else if (counter_rst) begin
         model_cnt <= 8'd20;
      end else if (increment && !decrement && model_cnt != 8'd255) begin
         model_cnt <= model_cnt + 8'd1;
      end else if (decrement && !increment && model_cnt != 8'd0) begin
         model_cnt <= model_cnt - 8'd1;
      end
   end

   // pulse tallies
   always @(posedge clk) begin
      if (increment) inc_total <= inc_total + 1;
      if (decrement) dec_total <= dec_total + 1;
      if (increment && decrement) both_cnt <= both_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_dec(input int limit, output int k);
      k = -1;
      for (int i = 1; i <= limit; i++) begin
         step(1);
         if (decrement) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      hit = 1'b0;
      force_en = 1'b0;
      force_val = 8'd0;
      step(3);
      n_cmp++;
      if ({counter_rst, increment, decrement, running, game_over} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {counter_rst, increment, decrement, running, game_over});
      end
      reset = 1'b1;
      step(1);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      step(1);
      n_cmp++;
      if ({counter_rst, increment, decrement, running, game_over} !== 5'b0) begin
         n_bad++;
         $display("FAIL pause_in_idle: got %b want 00000",
                  {counter_rst, increment, decrement, running, game_over});
      end
   endtask

   task automatic test_countdown;
      int k;
      int d0;
      int i0;
      int d1;
      d0 = dec_total;
      start = 1'b1;
      step(1);
      start = 1'b0;
      n_cmp++;
      if ({counter_rst, running} !== 2'b10) begin
         n_bad++;
         $display("FAIL load_cycle: got rst,run=%b want 10", {counter_rst, running});
      end
      step(1);
      n_cmp++;
      if ({counter_rst, running} !== 2'b01) begin
         n_bad++;
         $display("FAIL run_entry: got rst,run=%b want 01", {counter_rst, running});
      end
      n_cmp++;
      if (time_count !== 8'd20) begin
         n_bad++;
         $display("FAIL reload_value: got %0d want 20", time_count);
      end
      wait_dec(30, k);
      n_cmp++;
      if (k !== 10) begin
         n_bad++;
         $display("FAIL first_dec_latency: got %0d want 10", k);
      end
      step(1);
      n_cmp++;
      if (time_count !== 8'd19) begin
         n_bad++;
         $display("FAIL first_dec_value: got %0d want 19", time_count);
      end
      k = -1;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (game_over) begin
            k = i;
            break;
         end
      end
      n_cmp++;
      if (k < 0) begin
         n_bad++;
         $display("FAIL game_over_timeout: got none want game_over within 300");
      end
      n_cmp++;
      if ({running, game_over} !== 2'b01 || time_count !== 8'd0) begin
         n_bad++;
         $display("FAIL over_state: got run,over=%b cnt=%0d want 01 cnt=0",
                  {running, game_over}, time_count);
      end
      n_cmp++;
      if (dec_total - d0 !== 20) begin
         n_bad++;
         $display("FAIL dec_count: got %0d want 20", dec_total - d0);
      end
      i0 = inc_total;
      d1 = dec_total;
      step(30);
      n_cmp++;
      if ((inc_total - i0) + (dec_total - d1) !== 0 || game_over !== 1'b1) begin
         n_bad++;
         $display("FAIL over_quiet: got pulses=%0d over=%b want 0 1",
                  (inc_total - i0) + (dec_total - d1), game_over);
      end
   endtask

   task automatic test_restart;
      start = 1'b1;
      step(1);
      start = 1'b0;
      n_cmp++;
      if ({counter_rst, game_over} !== 2'b10) begin
         n_bad++;
         $display("FAIL restart_load: got rst,over=%b want 10", {counter_rst, game_over});
      end
      step(1);
      n_cmp++;
      if ({counter_rst, running} !== 2'b01 || time_count !== 8'd20) begin
         n_bad++;
         $display("FAIL restart_run: got rst,run=%b cnt=%0d want 01 cnt=20",
                  {counter_rst, running}, time_count);
      end
      start = 1'b1;
      step(1);
      start = 1'b0;
      n_cmp++;
      if ({counter_rst, running} !== 2'b01) begin
         n_bad++;
         $display("FAIL start_ignored_run: got rst,run=%b want 01", {counter_rst, running});
      end
   endtask

   task automatic test_hits;
      int k;
      int c0;
      int i0;
      wait_dec(30, k);
      n_cmp++;
      if (k < 0) begin
         n_bad++;
         $display("FAIL hits_sync: got no decrement want one within 30");
      end
      c0 = int'(time_count);
      i0 = inc_total;
      hit = 1'b1;
      step(2);
      n_cmp++;
      if ({increment, decrement} !== 2'b10) begin
         n_bad++;
         $display("FAIL hits_first_inc: got inc,dec=%b want 10", {increment, decrement});
      end
      step(1);
      hit = 1'b0;
      step(5);
      n_cmp++;
      if (increment !== 1'b0) begin
         n_bad++;
         $display("FAIL hits_drained: got inc=%b want 0", increment);
      end
      step(1);
      n_cmp++;
      if (inc_total - i0 !== 6 || int'(time_count) !== c0 + 5) begin
         n_bad++;
         $display("FAIL hits_net: got incs=%0d cnt=%0d want 6 cnt=%0d",
                  inc_total - i0, time_count, c0 + 5);
      end
   endtask

   task automatic test_tick_collision;
      int k;
      wait_dec(30, k);
      step(8);
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(1);
      n_cmp++;
      if ({increment, decrement} !== 2'b01) begin
         n_bad++;
         $display("FAIL collide_dec_first: got inc,dec=%b want 01", {increment, decrement});
      end
      step(1);
      n_cmp++;
      if ({increment, decrement} !== 2'b10) begin
         n_bad++;
         $display("FAIL collide_inc_next: got inc,dec=%b want 10", {increment, decrement});
      end
      step(1);
      n_cmp++;
      if ({increment, decrement} !== 2'b10) begin
         n_bad++;
         $display("FAIL collide_inc_second: got inc,dec=%b want 10", {increment, decrement});
      end
   endtask

   task automatic test_pause;
      int k;
      int i0;
      int d0;
      wait_dec(30, k);
      step(4);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      n_cmp++;
      if ({running, decrement} !== 2'b00) begin
         n_bad++;
         $display("FAIL pause_enter: got run,dec=%b want 00", {running, decrement});
      end
      i0 = inc_total;
      d0 = dec_total;
      for (int i = 0; i < 50; i++) begin
         hit = (i % 10 == 3);
         step(1);
      end
      hit = 1'b0;
      n_cmp++;
      if ((inc_total - i0) + (dec_total - d0) !== 0 || running !== 1'b0) begin
         n_bad++;
         $display("FAIL pause_quiet: got pulses=%0d run=%b want 0 0",
                  (inc_total - i0) + (dec_total - d0), running);
      end
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      n_cmp++;
      if (running !== 1'b1) begin
         n_bad++;
         $display("FAIL resume: got run=%b want 1", running);
      end
      wait_dec(30, k);
      n_cmp++;
      if (k !== 6) begin
         n_bad++;
         $display("FAIL resume_dec_latency: got %0d want 6", k);
      end
      n_cmp++;
      if (inc_total - i0 !== 0) begin
         n_bad++;
         $display("FAIL paused_hits_ignored: got incs=%0d want 0", inc_total - i0);
      end
   endtask

   task automatic test_saturation;
      int i0;
      force_val = 8'd255;
      force_en = 1'b1;
      i0 = inc_total;
      hit = 1'b1;
      step(10);
      hit = 1'b0;
      step(3);
      n_cmp++;
      if (inc_total - i0 !== 0) begin
         n_bad++;
         $display("FAIL inc_blocked_255: got incs=%0d want 0", inc_total - i0);
      end
      i0 = inc_total;
      force_en = 1'b0;
      step(40);
      n_cmp++;
      if (inc_total - i0 !== 15) begin
         n_bad++;
         $display("FAIL bonus_saturation: got incs=%0d want 15", inc_total - i0);
      end
   endtask

   task automatic test_reset_mid_run;
      int i0;
      int d0;
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      reset = 1'b0;
      step(1);
      n_cmp++;
      if ({counter_rst, increment, decrement, running, game_over} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_abort: got %b want 00000",
                  {counter_rst, increment, decrement, running, game_over});
      end
      step(1);
      reset = 1'b1;
      i0 = inc_total;
      d0 = dec_total;
      step(20);
      n_cmp++;
      if ({counter_rst, increment, decrement, running, game_over} !== 5'b0 ||
          (inc_total - i0) + (dec_total - d0) !== 0) begin
         n_bad++;
         $display("FAIL idle_after_reset: got %b pulses=%0d want 00000 0",
                  {counter_rst, increment, decrement, running, game_over},
                  (inc_total - i0) + (dec_total - d0));
      end
      start = 1'b1;
      step(1);
      start = 1'b0;
      n_cmp++;
      if (counter_rst !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset_load: got rst=%b want 1", counter_rst);
      end
      step(1);
      n_cmp++;
      if (running !== 1'b1 || time_count !== 8'd20) begin
         n_bad++;
         $display("FAIL post_reset_run: got run=%b cnt=%0d want 1 20", running, time_count);
      end
      i0 = inc_total;
      step(9);
      n_cmp++;
      if (inc_total - i0 !== 0) begin
         n_bad++;
         $display("FAIL bonus_cleared: got incs=%0d want 0", inc_total - i0);
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_restart();
      test_hits();
      test_tick_collision();
      test_pause();
      test_saturation();
      test_reset_mid_run();
      n_cmp++;
      if (both_cnt !== 0) begin
         n_bad++;
         $display("FAIL inc_dec_exclusive: got %0d overlaps want 0", both_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
